// File: rtl/caracter_pkg.sv
// Shared constants for the "HOLA" text overlay: box origin, glyph geometry
// and the handful of row patterns the font is built from.
package caracter_pkg;
    localparam int X0_DEF  = 304;
    localparam int Y0_DEF  = 232;
    localparam int CHAR_W  = 8;
    localparam int CHAR_H  = 16;
    localparam int N_CHARS = 4;

    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_SIDES = 8'h42;
    localparam logic [7:0] GLYPH_BAR   = 8'h7E;
    localparam logic [7:0] GLYPH_ROUND = 8'h3C;
    localparam logic [7:0] GLYPH_LEFT  = 8'h40;
endpackage

// File: rtl/font_rom.sv
// 64x8 combinational font ROM for the glyphs H, O, L, A (16 rows each).
// Address is {char_idx[1:0], glyph_row[3:0]}; column c sits in data bit 7-c.
module font_rom
    import caracter_pkg::*;
(
    input  logic [5:0] i_addr,
    output logic [7:0] o_data
);
    logic [1:0] w_chr;
    logic [3:0] w_row;

    assign w_chr = i_addr[5:4];
    assign w_row = i_addr[3:0];

    // Rows 0, 1, 14 and 15 stay blank for every glyph.
    always_comb begin
        o_data = GLYPH_BLANK;
        if (w_row >= 4'd2 && w_row <= 4'd13) begin
            case (w_chr)
                2'd0: o_data = (w_row == 4'd7 || w_row == 4'd8) ? GLYPH_BAR : GLYPH_SIDES;
                2'd1: o_data = (w_row == 4'd2 || w_row == 4'd13) ? GLYPH_ROUND : GLYPH_SIDES;
                2'd2: o_data = (w_row == 4'd13) ? GLYPH_BAR : GLYPH_LEFT;
                default: begin
                    if (w_row == 4'd2)      o_data = GLYPH_ROUND;
                    else if (w_row == 4'd7) o_data = GLYPH_BAR;
                    else                    o_data = GLYPH_SIDES;
                end
            endcase
        end
    end
endmodule

// File: rtl/caracter.sv
// VGA text overlay: draws "HOLA" in a 32x16 box at (X0,Y0), coloured by the
// R/G/B switches, with a single registered output stage.
module caracter
    import caracter_pkg::*;
#(
    parameter int X0 = X0_DEF,
    parameter int Y0 = Y0_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       R,
    input  logic       G,
    input  logic       B,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic [5:0] rowad,
    output logic [2:0] posicion
);
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_box;
    logic [7:0] w_row;
    logic       w_font_bit;
    logic       w_pix_on;

    // Unsigned wrap makes pixels above/left of the origin land far outside.
    assign w_dx     = pixel_x - 10'(X0);
    assign w_dy     = pixel_y - 10'(Y0);
    assign w_in_box = (w_dx < 10'(CHAR_W * N_CHARS)) && (w_dy < 10'(CHAR_H));

    assign rowad    = w_in_box ? {w_dx[4:3], w_dy[3:0]} : 6'd0;
    assign posicion = w_in_box ? w_dx[2:0] : 3'd0;

    font_rom u_font_rom (
        .i_addr (rowad),
        .o_data (w_row)
    );

    assign w_font_bit = w_row[3'd7 - posicion];
    assign w_pix_on   = video_on & w_in_box & w_font_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= 1'b0;
            g <= 1'b0;
            b <= 1'b0;
        end else begin
            r <= w_pix_on & R;
            g <= w_pix_on & G;
            b <= w_pix_on & B;
        end
    end
endmodule

// File: tb/tb_caracter.sv
// Directed bench for caracter: table of pixel vectors plus hand sequences
// for asynchronous reset and colour toggling.
module tb_caracter;
    logic       clk = 1'b0;
    logic       rst;
    logic       video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       R, G, B;
    logic       r, g, b;
    logic [5:0] rowad;
    logic [2:0] posicion;

    int n_vec = 0;
    int n_err = 0;

    caracter dut (
        .clk      (clk),
        .rst      (rst),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .R        (R),
        .G        (G),
        .B        (B),
        .r        (r),
        .g        (g),
        .b        (b),
        .rowad    (rowad),
        .posicion (posicion)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vo;
        logic [9:0] px;
        logic [9:0] py;
        logic [2:0] sw;
        logic [5:0] e_rowad;
        logic [2:0] e_pos;
        logic [2:0] e_rgb;
    } vec_t;

    vec_t tbl[14];

    task automatic chk_rgb(input string name, input logic [2:0] exp);
        n_vec++;
        if ({r, g, b} !== exp) begin
            n_err++;
            $display("FAIL %s: rgb=%b expected %b", name, {r, g, b}, exp);
        end
    endtask

    task automatic chk_addr(input string name, input logic [5:0] e_ra, input logic [2:0] e_p);
        n_vec++;
        if (rowad !== e_ra || posicion !== e_p) begin
            n_err++;
            $display("FAIL %s: rowad=%0d posicion=%0d expected rowad=%0d posicion=%0d",
                     name, rowad, posicion, e_ra, e_p);
        end
    endtask

    task automatic drive(input logic vo, input logic [9:0] px, input logic [9:0] py,
                         input logic [2:0] sw);
        video_on = vo;
        pixel_x  = px;
        pixel_y  = py;
        {R, G, B} = sw;
    endtask

    initial begin
        //          vo  px   py   RGB     rowad pos rgb
        tbl[0]  = '{1, 302, 233, 3'b111, 0,  0, 3'b000}; // left of box
        tbl[1]  = '{1, 305, 234, 3'b111, 2,  1, 3'b111}; // H row 2 col 1
        tbl[2]  = '{1, 306, 234, 3'b111, 2,  2, 3'b000}; // H row 2 col 2
        tbl[3]  = '{0, 305, 234, 3'b111, 2,  1, 3'b000}; // blanking
        tbl[4]  = '{1, 323, 245, 3'b100, 45, 3, 3'b100}; // L bottom bar, red
        tbl[5]  = '{1, 323, 247, 3'b111, 47, 3, 3'b000}; // row 15 blank
        tbl[6]  = '{1, 336, 240, 3'b111, 0,  0, 3'b000}; // right of box
        tbl[7]  = '{1, 335, 240, 3'b111, 56, 7, 3'b000}; // A col 7
        tbl[8]  = '{1, 304, 239, 3'b111, 7,  0, 3'b000}; // H bar col 0
        tbl[9]  = '{1, 305, 239, 3'b011, 7,  1, 3'b011}; // H bar col 1
        tbl[10] = '{1, 314, 234, 3'b010, 18, 2, 3'b010}; // O top round
        tbl[11] = '{1, 305, 231, 3'b111, 0,  0, 3'b000}; // above box (wrap)
        tbl[12] = '{1, 330, 234, 3'b001, 50, 2, 3'b001}; // A top round
        tbl[13] = '{1, 305, 232, 3'b111, 0,  1, 3'b000}; // row 0 blank

        rst = 1'b0;
        drive(1, 305, 234, 3'b111);
        #2;
        chk_rgb("reset_state", 3'b000);
        chk_addr("reset_addr", 6'd2, 3'd1);
        @(negedge clk);
        chk_rgb("reset_held", 3'b000);
        rst = 1'b1;
        #1;
        chk_rgb("reset_release_pre_edge", 3'b000);
        @(negedge clk);
        chk_rgb("reset_release_edge", 3'b111);

        // Mid-frame async reset: outputs drop without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk_rgb("async_reset_immediate", 3'b000);
        @(negedge clk);
        chk_rgb("async_reset_held", 3'b000);
        rst = 1'b1;
        @(negedge clk);
        chk_rgb("async_reset_recover", 3'b111);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vo, tbl[i].px, tbl[i].py, tbl[i].sw);
            #1;
            chk_addr($sformatf("vec%0d_addr", i), tbl[i].e_rowad, tbl[i].e_pos);
            chk_rgb($sformatf("vec%0d_pre_edge", i), (i == 0) ? 3'b111 : tbl[i-1].e_rgb);
            @(negedge clk);
            chk_rgb($sformatf("vec%0d_rgb", i), tbl[i].e_rgb);
        end

        // Colour switches toggled on a held lit pixel take effect next edge.
        drive(1, 305, 234, 3'b100);
        @(negedge clk);
        chk_rgb("toggle_r", 3'b100);
        {R, G, B} = 3'b010;
        #1;
        chk_rgb("toggle_hold_until_edge", 3'b100);
        @(negedge clk);
        chk_rgb("toggle_g", 3'b010);
        {R, G, B} = 3'b001;
        @(negedge clk);
        chk_rgb("toggle_b", 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
